// File: rtl/datapath_pkg.sv
// Shared types and helpers for the sequenced single-bus datapath.
// Configuration macro: DATAPATH_MULDIV_EN selects whether MUL (opcode 11) is
// a legal ALU operation or is rejected as illegal.
package datapath_pkg;

  typedef enum logic [4:0] {
    OP_ADD  = 5'd0,
    OP_SUB  = 5'd1,
    OP_AND  = 5'd2,
    OP_OR   = 5'd3,
    OP_SHR  = 5'd4,
    OP_SHL  = 5'd5,
    OP_ROR  = 5'd6,
    OP_ROL  = 5'd7,
    OP_ADDI = 5'd8,
    OP_NEG  = 5'd9,
    OP_NOT  = 5'd10,
    OP_MUL  = 5'd11,
    OP_MFHI = 5'd12,
    OP_MFLO = 5'd13,
    OP_IN   = 5'd14,
    OP_OUT  = 5'd15
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TY,
    ST_TZ,
    ST_TWB,
    ST_FIN
  } state_e;

  // ALU ops walk TY/TZ/TWB, move ops go straight to TWB, illegal ops to FIN.
  typedef enum logic [1:0] {
    CLS_ALU,
    CLS_MOVE,
    CLS_ILLEGAL
  } op_class_e;

  // Widest datapath the sign-extension helper supports.
  localparam int SEXT_MAX_W = 64;

  function automatic op_class_e op_class(input logic [4:0] op);
    op_class_e cls;
    if (op == OP_MUL) begin
`ifdef DATAPATH_MULDIV_EN
      cls = CLS_ALU;
`else
      cls = CLS_ILLEGAL;
`endif
    end else if (op < 5'd12) begin
      cls = CLS_ALU;
    end else if (op < 5'd16) begin
      cls = CLS_MOVE;
    end else begin
      cls = CLS_ILLEGAL;
    end
    return cls;
  endfunction

  // Replicates bit imm_w-1 into every bit above it; callers truncate.
  function automatic logic [SEXT_MAX_W-1:0] sign_extend(
    input logic [SEXT_MAX_W-1:0] imm,
    input int                    imm_w
  );
    logic [SEXT_MAX_W-1:0] mask;
    logic [SEXT_MAX_W-1:0] sign_sel;
    mask     = (SEXT_MAX_W'(1) << imm_w) - SEXT_MAX_W'(1);
    sign_sel = SEXT_MAX_W'(1) << (imm_w - 1);
    return (imm & mask) | (((imm & sign_sel) != '0) ? ~mask : '0);
  endfunction

endpackage

// File: rtl/bus_datapath_seq_alu.sv
// Combinational ALU for the sequenced datapath: Z = ALU(Y, bus).
// Configuration macro: DATAPATH_MULDIV_EN adds the signed 2*DATA_W multiplier;
// without it opcode 11 yields zero (the sequencer never issues it anyway).
module dp_alu
  import datapath_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] y,
  input  logic [DATA_W-1:0] bus,
  input  logic [4:0]        op,
  output logic [DATA_W-1:0] z_hi,
  output logic [DATA_W-1:0] z_lo
);

  localparam int SH_W = $clog2(DATA_W);
  localparam logic [SH_W:0] W_AMT = DATA_W[SH_W:0];

  logic [SH_W-1:0]   sh;
  logic [DATA_W-1:0] ror_val;
  logic [DATA_W-1:0] rol_val;

  // Shift/rotate amount comes from the low bits of the source-B bus value.
  assign sh = bus[SH_W-1:0];

  // A shift by the full width yields zero, so sh == 0 rotates cleanly.
  assign ror_val = (y >> sh) | (y << (W_AMT - {1'b0, sh}));
  assign rol_val = (y << sh) | (y >> (W_AMT - {1'b0, sh}));

`ifdef DATAPATH_MULDIV_EN
  logic signed [2*DATA_W-1:0] prod;
  assign prod = $signed({{DATA_W{y[DATA_W-1]}}, y}) *
                $signed({{DATA_W{bus[DATA_W-1]}}, bus});
`endif

  // Operation select; Zhi stays zero except for MUL.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    z_hi = '0;
    z_lo = '0;
    case (op)
      OP_ADD,
      OP_ADDI: z_lo = y + bus;
      OP_SUB:  z_lo = y - bus;
      OP_AND:  z_lo = y & bus;
      OP_OR:   z_lo = y | bus;
      OP_SHR:  z_lo = y >> sh;
      OP_SHL:  z_lo = y << sh;
      OP_ROR:  z_lo = ror_val;
      OP_ROL:  z_lo = rol_val;
      OP_NEG:  z_lo = '0 - y;
      OP_NOT:  z_lo = ~y;
`ifdef DATAPATH_MULDIV_EN
      OP_MUL:  {z_hi, z_lo} = prod;
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/bus_datapath_seq.sv
// Single-bus CPU datapath with an internal phase sequencer. One command per
// valid/ready handshake is stepped through Y-load, ALU and write-back phases.
// Configuration macro: DATAPATH_MULDIV_EN enables MUL and the HI/LO write path.
module bus_datapath_seq
  import datapath_pkg::*;
#(
  parameter  int DATA_W   = 32,
  parameter  int NUM_REGS = 16,
  parameter  int IMM_W    = 19,
  localparam int RSEL_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [4:0]        cmd_op,
  input  logic [RSEL_W-1:0] cmd_ra,
  input  logic [RSEL_W-1:0] cmd_rb,
  input  logic [RSEL_W-1:0] cmd_rc,
  input  logic [IMM_W-1:0]  cmd_imm,
  input  logic [DATA_W-1:0] in_port,
  output logic [DATA_W-1:0] out_port,
  output logic              done,
  output logic              illegal,
  output logic [DATA_W-1:0] bus,
  input  logic [RSEL_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  state_e            state_q, state_d;
  op_class_e         cls_in, cls_q;
  logic [4:0]        op_q;
  logic [RSEL_W-1:0] ra_q, rb_q, rc_q;
  logic [IMM_W-1:0]  imm_q;

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] y_q;
  logic [DATA_W-1:0] z_hi_q, z_lo_q;
  logic [DATA_W-1:0] hi_q, lo_q;
  logic [DATA_W-1:0] out_q;

  logic [DATA_W-1:0] bus_val;
  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] alu_hi, alu_lo;
  logic              accept;
  logic              in_twb;
  logic              rf_we;
  logic              hilo_we;
  logic              out_we;

  assign cmd_ready = (state_q == ST_IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign cls_in    = op_class(cmd_op);
  assign done      = (state_q == ST_FIN);
  assign illegal   = done && (cls_q == CLS_ILLEGAL);
  assign out_port  = out_q;
  assign bus       = bus_val;
  assign dbg_data  = regs[dbg_addr];
  assign imm_ext   = DATA_W'(sign_extend(SEXT_MAX_W'(imm_q), IMM_W));

  assign in_twb  = (state_q == ST_TWB);
  assign rf_we   = in_twb && (((cls_q == CLS_ALU) && (op_q != OP_MUL)) ||
                              (op_q == OP_MFHI) || (op_q == OP_MFLO) ||
                              (op_q == OP_IN));
  assign hilo_we = in_twb && (cls_q == CLS_ALU) && (op_q == OP_MUL);
  assign out_we  = in_twb && (op_q == OP_OUT);

  dp_alu #(.DATA_W(DATA_W)) u_alu (
    .y    (y_q),
    .bus  (bus_val),
    .op   (op_q),
    .z_hi (alu_hi),
    .z_lo (alu_lo)
  );

  // Sequencer state register; reset abandons any in-flight command.
  always_ff @(posedge clk or negedge clr) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!clr) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next-state: pick the phase path from the opcode class at accept.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (cls_in)
            CLS_ALU:  state_d = ST_TY;
            CLS_MOVE: state_d = ST_TWB;
            default:  state_d = ST_FIN;
          endcase
        end
      end
      ST_TY:   state_d = ST_TZ;
      ST_TZ:   state_d = ST_TWB;
      ST_TWB:  state_d = ST_FIN;
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Capture the command fields at the handshake; held for the whole sequence.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      op_q  <= '0;
      cls_q <= CLS_ALU;
      ra_q  <= '0;
      rb_q  <= '0;
      rc_q  <= '0;
      imm_q <= '0;
    end else if (accept) begin
      op_q  <= cmd_op;
      cls_q <= cls_in;
      ra_q  <= cmd_ra;
      rb_q  <= cmd_rb;
      rc_q  <= cmd_rc;
      imm_q <= cmd_imm;
    end
  end

  // Shared bus driver: one source per phase, zero when idle or finishing.
  always_comb begin
    bus_val = '0;
    case (state_q)
      ST_TY: bus_val = regs[rb_q];
      ST_TZ: bus_val = (op_q == OP_ADDI) ? imm_ext : regs[rc_q];
      ST_TWB: begin
        if (cls_q == CLS_ALU) begin
          bus_val = z_lo_q;
        end else begin
          case (op_q)
            OP_MFHI: bus_val = hi_q;
            OP_MFLO: bus_val = lo_q;
            OP_IN:   bus_val = in_port;
            OP_OUT:  bus_val = regs[rb_q];
            default: bus_val = '0;
          endcase
        end
      end
      default: bus_val = '0;
    endcase
  end

  // General register file, written from the bus in the write-back phase.
  always_ff @(posedge clk or negedge clr) begin
    // NOTE: the register file is architecturally cleared by reset, so it is
    // built from flops rather than an unreset RAM macro.
    if (!clr) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (rf_we) begin
      regs[ra_q] <= bus_val;
    end
  end

  // Y latches source A; Z latches the ALU result one phase later.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      y_q    <= '0;
      z_hi_q <= '0;
      z_lo_q <= '0;
    end else begin
      if (state_q == ST_TY) y_q <= bus_val;
      if (state_q == ST_TZ) {z_hi_q, z_lo_q} <= {alu_hi, alu_lo};
    end
  end

  // HI/LO take the full product; unreachable when MUL is not legal.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (hilo_we) begin
      hi_q <= z_hi_q;
      lo_q <= z_lo_q;
    end
  end

  // OutPort register loads from the bus on OUT write-back.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr)        out_q <= '0;
    else if (out_we) out_q <= bus_val;
  end

endmodule

// File: tb/tb_bus_datapath_seq.sv
// Directed self-checking bench for bus_datapath_seq (default parameters).
// Honours DATAPATH_MULDIV_EN for the MUL expectations.
module tb_bus_datapath_seq;

  logic        clk;
  logic        clr;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [4:0]  cmd_op;
  logic [3:0]  cmd_ra, cmd_rb, cmd_rc;
  logic [18:0] cmd_imm;
  logic [31:0] in_port;
  logic [31:0] out_port;
  logic        done;
  logic        illegal;
  logic [31:0] bus;
  logic [3:0]  dbg_addr;
  logic [31:0] dbg_data;

  int pass_cnt  = 0;
  int check_cnt = 0;

  bus_datapath_seq dut (
    .clk       (clk),
    .clr       (clr),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_ra    (cmd_ra),
    .cmd_rb    (cmd_rb),
    .cmd_rc    (cmd_rc),
    .cmd_imm   (cmd_imm),
    .in_port   (in_port),
    .out_port  (out_port),
    .done      (done),
    .illegal   (illegal),
    .bus       (bus),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data)
  );

  always #5 clk = ~clk;

  // Issue one command and report the done cycle (accept edge = 0, -1 on
  // timeout), the illegal flag at done, the bus one cycle before done, and
  // whether the sequencer is idle with done low one cycle after done.
  task automatic run_cmd(input logic [4:0] op, input logic [3:0] ra, rb, rc,
                         input logic [18:0] imm, input logic [31:0] inp,
                         output int dcyc, output logic ill,
                         output logic [31:0] wb_bus, output logic rdy_after);
    int          waited;
    logic [31:0] prev_bus;
    waited = 0;
    @(negedge clk);
    while (!cmd_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    cmd_op = op; cmd_ra = ra; cmd_rb = rb; cmd_rc = rc; cmd_imm = imm;
    in_port = inp;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    dcyc = -1; ill = 1'b0; prev_bus = '0;
    for (int c = 1; c <= 8; c++) begin
      if (done) begin
        dcyc = c;
        ill  = illegal;
        break;
      end
      prev_bus = bus;
      @(posedge clk); #1;
    end
    wb_bus = prev_bus;
    @(posedge clk); #1;
    rdy_after = cmd_ready && !done;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] v);
    dbg_addr = a;
    #1;
    v = dbg_data;
  endtask

  task automatic test_reset;
    logic [31:0] v;
    int          bad;
    repeat (2) @(posedge clk);
    #1;
    check_cnt++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else pass_cnt++;
    check_cnt++; if (illegal !== 1'b0) $display("FAIL reset_illegal got=%b exp=0", illegal); else pass_cnt++;
    check_cnt++; if (bus !== 32'h0) $display("FAIL reset_bus got=%h exp=0", bus); else pass_cnt++;
    check_cnt++; if (out_port !== 32'h0) $display("FAIL reset_out_port got=%h exp=0", out_port); else pass_cnt++;
    @(negedge clk);
    clr = 1'b1;
    #1;
    check_cnt++; if (cmd_ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", cmd_ready); else pass_cnt++;
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      rd(4'(i), v);
      if (v !== 32'h0) bad++;
    end
    check_cnt++; if (bad !== 0) $display("FAIL reset_regs nonzero_count=%0d exp=0", bad); else pass_cnt++;
  endtask

  task automatic test_in;
    int dc; logic il, rdy; logic [31:0] wb, v;
    run_cmd(5'd14, 4'd2, 4'd0, 4'd0, '0, 32'h0000_0007, dc, il, wb, rdy);
    check_cnt++; if (dc !== 2) $display("FAIL in_r2_done_cycle got=%0d exp=2", dc); else pass_cnt++;
    check_cnt++; if (wb !== 32'h7) $display("FAIL in_r2_bus got=%h exp=00000007", wb); else pass_cnt++;
    check_cnt++; if (rdy !== 1'b1) $display("FAIL in_r2_ready_after got=%b exp=1", rdy); else pass_cnt++;
    rd(4'd2, v);
    check_cnt++; if (v !== 32'h7) $display("FAIL in_r2_value got=%h exp=00000007", v); else pass_cnt++;
    run_cmd(5'd14, 4'd4, 4'd0, 4'd0, '0, 32'h0000_0003, dc, il, wb, rdy);
    check_cnt++; if (dc !== 2) $display("FAIL in_r4_done_cycle got=%0d exp=2", dc); else pass_cnt++;
    rd(4'd4, v);
    check_cnt++; if (v !== 32'h3) $display("FAIL in_r4_value got=%h exp=00000003", v); else pass_cnt++;
    run_cmd(5'd14, 4'd3, 4'd0, 4'd0, '0, 32'd33, dc, il, wb, rdy);
    rd(4'd3, v);
    check_cnt++; if (v !== 32'd33) $display("FAIL in_r3_value got=%h exp=00000021", v); else pass_cnt++;
  endtask

  typedef struct {
    string       name;
    logic [4:0]  op;
    logic [3:0]  ra, rb, rc;
    logic [18:0] imm;
    logic [31:0] exp;
  } vec_t;

  // Starting state: R2=7, R3=33 (shift amount 1), R4=3.
  task automatic test_alu_ops;
    vec_t        vecs[12];
    int          dc; logic il, rdy; logic [31:0] wb, v;
    vecs = '{
      '{"add",   5'd0,  4'd5,  4'd2, 4'd4, 19'h0,     32'h0000_000A},
      '{"addi",  5'd8,  4'd1,  4'd5, 4'd0, 19'h7FFFF, 32'h0000_0009},
      '{"sub",   5'd1,  4'd7,  4'd4, 4'd2, 19'h0,     32'hFFFF_FFFC},
      '{"ror",   5'd6,  4'd6,  4'd2, 4'd3, 19'h0,     32'h8000_0003},
      '{"rol",   5'd7,  4'd12, 4'd6, 4'd3, 19'h0,     32'h0000_0007},
      '{"shr",   5'd4,  4'd13, 4'd6, 4'd3, 19'h0,     32'h4000_0001},
      '{"shl",   5'd5,  4'd14, 4'd2, 4'd3, 19'h0,     32'h0000_000E},
      '{"and",   5'd2,  4'd15, 4'd2, 4'd4, 19'h0,     32'h0000_0003},
      '{"or",    5'd3,  4'd0,  4'd5, 4'd4, 19'h0,     32'h0000_000B},
      '{"neg",   5'd9,  4'd10, 4'd2, 4'd4, 19'h0,     32'hFFFF_FFF9},
      '{"not",   5'd10, 4'd11, 4'd4, 4'd2, 19'h0,     32'hFFFF_FFFC},
      '{"alias", 5'd0,  4'd2,  4'd2, 4'd2, 19'h0,     32'h0000_000E}
    };
    for (int i = 0; i < 12; i++) begin
      run_cmd(vecs[i].op, vecs[i].ra, vecs[i].rb, vecs[i].rc, vecs[i].imm, 32'h0,
              dc, il, wb, rdy);
      rd(vecs[i].ra, v);
      check_cnt++; if (dc !== 4) $display("FAIL %s_done_cycle got=%0d exp=4", vecs[i].name, dc); else pass_cnt++;
      check_cnt++; if (il !== 1'b0) $display("FAIL %s_illegal got=%b exp=0", vecs[i].name, il); else pass_cnt++;
      check_cnt++; if (wb !== vecs[i].exp) $display("FAIL %s_twb_bus got=%h exp=%h", vecs[i].name, wb, vecs[i].exp); else pass_cnt++;
      check_cnt++; if (v !== vecs[i].exp) $display("FAIL %s_result got=%h exp=%h", vecs[i].name, v, vecs[i].exp); else pass_cnt++;
      check_cnt++; if (rdy !== 1'b1) $display("FAIL %s_ready_cycle5 got=%b exp=1", vecs[i].name, rdy); else pass_cnt++;
    end
  endtask

  task automatic test_out;
    int dc; logic il, rdy; logic [31:0] wb;
    run_cmd(5'd15, 4'd0, 4'd5, 4'd0, '0, 32'h0, dc, il, wb, rdy);
    check_cnt++; if (dc !== 2) $display("FAIL out_done_cycle got=%0d exp=2", dc); else pass_cnt++;
    check_cnt++; if (out_port !== 32'hA) $display("FAIL out_port got=%h exp=0000000a", out_port); else pass_cnt++;
  endtask

  task automatic test_mul;
    int dc; logic il, rdy; logic [31:0] wb, v;
    run_cmd(5'd14, 4'd8, 4'd0, 4'd0, '0, 32'hFFFF_FFFF, dc, il, wb, rdy);
    run_cmd(5'd11, 4'd9, 4'd8, 4'd8, '0, 32'h0, dc, il, wb, rdy);
`ifdef DATAPATH_MULDIV_EN
    check_cnt++; if (dc !== 4) $display("FAIL mul_done_cycle got=%0d exp=4", dc); else pass_cnt++;
    check_cnt++; if (il !== 1'b0) $display("FAIL mul_illegal got=%b exp=0", il); else pass_cnt++;
    run_cmd(5'd12, 4'd10, 4'd0, 4'd0, '0, 32'h0, dc, il, wb, rdy);
    rd(4'd10, v);
    check_cnt++; if (v !== 32'h0) $display("FAIL mul_hi got=%h exp=00000000", v); else pass_cnt++;
    run_cmd(5'd13, 4'd11, 4'd0, 4'd0, '0, 32'h0, dc, il, wb, rdy);
    rd(4'd11, v);
    check_cnt++; if (v !== 32'h1) $display("FAIL mul_lo got=%h exp=00000001", v); else pass_cnt++;
`else
    check_cnt++; if (dc !== 1) $display("FAIL mul_done_cycle got=%0d exp=1", dc); else pass_cnt++;
    check_cnt++; if (il !== 1'b1) $display("FAIL mul_illegal got=%b exp=1", il); else pass_cnt++;
    run_cmd(5'd12, 4'd10, 4'd0, 4'd0, '0, 32'h0, dc, il, wb, rdy);
    rd(4'd10, v);
    check_cnt++; if (v !== 32'h0) $display("FAIL mfhi_off got=%h exp=00000000", v); else pass_cnt++;
    run_cmd(5'd13, 4'd11, 4'd0, 4'd0, '0, 32'h0, dc, il, wb, rdy);
    rd(4'd11, v);
    check_cnt++; if (v !== 32'h0) $display("FAIL mflo_off got=%h exp=00000000", v); else pass_cnt++;
`endif
    rd(4'd9, v);
    check_cnt++; if (v !== 32'h0) $display("FAIL mul_no_reg_write got=%h exp=00000000", v); else pass_cnt++;
  endtask

  task automatic test_illegal;
    int dc; logic il, rdy; logic [31:0] wb, v;
    run_cmd(5'd20, 4'd5, 4'd2, 4'd4, '0, 32'h0, dc, il, wb, rdy);
    check_cnt++; if (dc !== 1) $display("FAIL illegal_done_cycle got=%0d exp=1", dc); else pass_cnt++;
    check_cnt++; if (il !== 1'b1) $display("FAIL illegal_flag got=%b exp=1", il); else pass_cnt++;
    check_cnt++; if (rdy !== 1'b1) $display("FAIL illegal_ready_after got=%b exp=1", rdy); else pass_cnt++;
    rd(4'd5, v);
    check_cnt++; if (v !== 32'hA) $display("FAIL illegal_no_write got=%h exp=0000000a", v); else pass_cnt++;
  endtask

  // IN r3 then OUT r3 held valid through FIN: OUT accepted on the IDLE cycle.
  task automatic test_back_to_back;
    @(negedge clk);
    cmd_op = 5'd14; cmd_ra = 4'd3; cmd_rb = 4'd0; cmd_rc = 4'd0; cmd_imm = '0;
    in_port = 32'h0000_0055;
    cmd_valid = 1'b1;
    @(posedge clk); #1;                       // cycle 1: TWB of IN
    cmd_op = 5'd15; cmd_rb = 4'd3;
    @(posedge clk); #1;                       // cycle 2: FIN of IN
    check_cnt++; if (done !== 1'b1) $display("FAIL b2b_first_done got=%b exp=1", done); else pass_cnt++;
    check_cnt++; if (cmd_ready !== 1'b0) $display("FAIL b2b_ready_in_fin got=%b exp=0", cmd_ready); else pass_cnt++;
    @(posedge clk); #1;                       // cycle 3: IDLE, OUT accepted at end
    check_cnt++; if (cmd_ready !== 1'b1) $display("FAIL b2b_ready_idle got=%b exp=1", cmd_ready); else pass_cnt++;
    @(posedge clk); #1;                       // OUT cycle 1: TWB
    cmd_valid = 1'b0;
    check_cnt++; if (cmd_ready !== 1'b0) $display("FAIL b2b_second_accepted got=%b exp=0", cmd_ready); else pass_cnt++;
    @(posedge clk); #1;                       // OUT cycle 2: FIN
    check_cnt++; if (done !== 1'b1) $display("FAIL b2b_second_done got=%b exp=1", done); else pass_cnt++;
    check_cnt++; if (out_port !== 32'h55) $display("FAIL b2b_out_port got=%h exp=00000055", out_port); else pass_cnt++;
    @(posedge clk); #1;
    check_cnt++; if (done !== 1'b0) $display("FAIL b2b_done_pulse got=%b exp=0", done); else pass_cnt++;
  endtask

  task automatic test_reset_midflight;
    int dc; logic il, rdy, seen; logic [31:0] wb, v;
    @(negedge clk);
    cmd_op = 5'd0; cmd_ra = 4'd5; cmd_rb = 4'd2; cmd_rc = 4'd4; cmd_imm = '0;
    cmd_valid = 1'b1;
    @(posedge clk); #1;                       // cycle 1: TY
    cmd_valid = 1'b0;
    @(posedge clk); #1;                       // cycle 2: TZ
    clr = 1'b0;
    #1;
    check_cnt++; if (done !== 1'b0) $display("FAIL midrst_done got=%b exp=0", done); else pass_cnt++;
    check_cnt++; if (out_port !== 32'h0) $display("FAIL midrst_out_port got=%h exp=0", out_port); else pass_cnt++;
    rd(4'd5, v);
    check_cnt++; if (v !== 32'h0) $display("FAIL midrst_r5 got=%h exp=0", v); else pass_cnt++;
    rd(4'd2, v);
    check_cnt++; if (v !== 32'h0) $display("FAIL midrst_r2 got=%h exp=0", v); else pass_cnt++;
    seen = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    @(negedge clk);
    clr = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    check_cnt++; if (seen !== 1'b0) $display("FAIL midrst_no_done got=%b exp=0", seen); else pass_cnt++;
    rd(4'd5, v);
    check_cnt++; if (v !== 32'h0) $display("FAIL midrst_r5_after got=%h exp=0", v); else pass_cnt++;
    run_cmd(5'd14, 4'd2, 4'd0, 4'd0, '0, 32'h0000_0005, dc, il, wb, rdy);
    check_cnt++; if (dc !== 2) $display("FAIL midrst_next_done got=%0d exp=2", dc); else pass_cnt++;
    rd(4'd2, v);
    check_cnt++; if (v !== 32'h5) $display("FAIL midrst_next_r2 got=%h exp=00000005", v); else pass_cnt++;
  endtask

  initial begin
    clk = 1'b0; clr = 1'b0; cmd_valid = 1'b0;
    cmd_op = '0; cmd_ra = '0; cmd_rb = '0; cmd_rc = '0; cmd_imm = '0;
    in_port = '0; dbg_addr = '0;
    test_reset();
    test_in();
    test_alu_ops();
    test_out();
    test_mul();
    test_illegal();
    test_back_to_back();
    test_reset_midflight();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
